cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Collects completed results from the three execution units (adder, multiplier, load unit) and drives the single common data bus (CDB) each cycle.
- The CDB is consumed by the reorder buffer through its cdb_rob_dest / cdb_data / CTRL_incoming_data / CTRL_PC inputs, and by the reservation stations through the RS tag.
- Each unit gets a small skid FIFO so that a lost arbitration never stalls a unit's pipeline.
- One result is broadcast per cycle, chosen by fair round-robin; a branch flush discards all pending results.

Parameters:
- ROB_TAG_W, 2, width of the ROB entry index carried with each result.
- DATA_W, 64, result data width.
- RS_TAG_W, 4, reservation-station tag width (notag=0, add_1..st_2 = 1..10).
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  mispredict flush from the ROB (CTRL_flushRegFile); synchronous.
- add_valid / mul_valid / ld_valid  in  1 each  unit presents a result this cycle.
- add_ready / mul_ready / ld_ready  out  1 each  FIFO can accept a result.
- add_rob_id / mul_rob_id / ld_rob_id  in  ROB_TAG_W each  destination ROB entry.
- add_rs_tag / mul_rs_tag / ld_rs_tag  in  RS_TAG_W each  producing RS tag.
- add_data / mul_data / ld_data  in  DATA_W each  result value.
- add_taken  in  1  branch-taken flag; adder only (branches resolve there). Mul and ld entries carry 0.
- cdb_valid  out  1  broadcast valid (drives ROB CTRL_incoming_data).
- cdb_rob_dest  out  ROB_TAG_W  ROB entry written.
- cdb_rs_tag  out  RS_TAG_W  tag broadcast to reservation stations.
- cdb_data  out  DATA_W  broadcast value.
- cdb_taken  out  1  branch outcome (drives ROB CTRL_PC).

Behaviour:
- Reset (async, rst=1):
  - All FIFOs empty.
  - All cdb_* outputs 0.
  - All *_ready = 1.
  - RR pointer = add (0).
- Handshake:
  - A transfer occurs when x_valid & x_ready at a clk edge; the entry is pushed into that source's FIFO.
  - x_ready = (count_x < FIFO_DEPTH), taken from registered count. A full FIFO does not accept a push in the same cycle it pops.
  - Units must hold valid and payload stable until ready.
- Arbitration, every cycle:
  - Candidates are the sources whose FIFO is non-empty at cycle start. A result pushed in cycle N is not a candidate before cycle N+1.
  - Search order starts at the RR pointer: add → mul → ld → add.
  - The first non-empty source wins. Its head is popped and registered onto cdb_* at the same edge.
  - Pointer becomes (winner+1) mod 3. The pointer is unchanged when there is no winner.
- Output timing:
  - cdb_* are registered.
  - cdb_valid is high for exactly one cycle per popped entry.
  - When no source wins, cdb_valid=0 and the other cdb_* fields hold their previous values.
  - Minimum latency from handshake to cdb_valid is 2 edges: push at edge N, pop/broadcast at edge N+1, visible in the cycle after N+1.
- FIFO ordering: per source, strictly FIFO. Push and pop in the same cycle on a non-full FIFO are both performed; count is unchanged.
- Flush (synchronous, highest priority):
  - All FIFOs are emptied.
  - Same-cycle pushes are discarded.
  - No pop occurs; cdb_valid=0 on the next cycle.
  - RR pointer resets to add.
- rst asserted mid-operation clears everything immediately, independent of clk.
- Throughput: 1 result/cycle aggregate. Any persistently non-empty source is served at least once every 3 cycles.

Decomposition:
- Shared package cpu_pkg:
  - RS tag constants (notag, add_1..add_3, mult_1, mult_2, ld_1..ld_3, st_1, st_2).
  - DATA_W and ROB_TAG_W.
  - cdb_entry struct: rob_id, rs_tag, data, taken.
- One sub-module: cdb_fifo, a parameterised FIFO_DEPTH skid FIFO of cdb_entry with push, pop, flush, count, full and empty. Instantiated three times.
- Arbiter and output register live in the top module.

Test Plan:
- Reset then idle → all ready=1, cdb_valid=0 for 10 cycles.
- Single add push (rob_id=2, rs_tag=add_1, data=0x1234, taken=0) → two cycles later, cdb_valid=1 for one cycle with rob_dest=2, rs_tag=1, data=0x1234, taken=0.
- All three units push in the same cycle (add data=A, mul data=B, ld data=C), pointer at add → cdb emits A, B, C on consecutive cycles; pointer ends at add.
- Continuous mul valid with FIFO held full, plus one add push → add_ready stays 1; mul_ready drops after 2 accepts; add is broadcast within 3 cycles; no mul entry is lost or reordered (check the data sequence 1, 2, 3, ...).
- Add branch push with taken=1, rob_id=1 → cdb_taken=1 and cdb_rob_dest=1 in the same broadcast cycle.
- Fill the ld FIFO (2 entries), assert flush for 1 cycle with a simultaneous add push → no broadcast follows, all ready=1 next cycle, and the discarded add result never appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, RS tag encodings, CDB entry type and round-robin helper
// Used by: cdb_fifo, cdb_arbiter_if, cdb_arbiter
package cpu_pkg;
  localparam int DATA_W = 64;
  localparam int ROB_TAG_W = 2;
  localparam int RS_TAG_W = 4;
  localparam logic [RS_TAG_W-1:0] notag = 4'd0;
  localparam logic [RS_TAG_W-1:0] add_1 = 4'd1;
  localparam logic [RS_TAG_W-1:0] add_2 = 4'd2;
  localparam logic [RS_TAG_W-1:0] add_3 = 4'd3;
  localparam logic [RS_TAG_W-1:0] mult_1 = 4'd4;
  localparam logic [RS_TAG_W-1:0] mult_2 = 4'd5;
  localparam logic [RS_TAG_W-1:0] ld_1 = 4'd6;
  localparam logic [RS_TAG_W-1:0] ld_2 = 4'd7;
  localparam logic [RS_TAG_W-1:0] ld_3 = 4'd8;
  localparam logic [RS_TAG_W-1:0] st_1 = 4'd9;
  localparam logic [RS_TAG_W-1:0] st_2 = 4'd10;
  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_id;
    logic [RS_TAG_W-1:0] rs_tag;
    logic [DATA_W-1:0] data;
    logic taken;
  } cdb_entry;
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result handshakes from adder/multiplier/load unit plus the CDB broadcast
// master: execution units and ROB/RS side; slave: the arbiter
interface cdb_arbiter_if;
  import cpu_pkg::*;
  logic flush;
  logic add_valid, mul_valid, ld_valid;
  logic add_ready, mul_ready, ld_ready;
  logic [ROB_TAG_W-1:0] add_rob_id, mul_rob_id, ld_rob_id;
  logic [RS_TAG_W-1:0] add_rs_tag, mul_rs_tag, ld_rs_tag;
  logic [DATA_W-1:0] add_data, mul_data, ld_data;
  logic add_taken;
  logic cdb_valid;
  logic [ROB_TAG_W-1:0] cdb_rob_dest;
  logic [RS_TAG_W-1:0] cdb_rs_tag;
  logic [DATA_W-1:0] cdb_data;
  logic cdb_taken;
  modport master (
    output flush, add_valid, mul_valid, ld_valid, add_rob_id, mul_rob_id, ld_rob_id,
           add_rs_tag, mul_rs_tag, ld_rs_tag, add_data, mul_data, ld_data, add_taken,
    input  add_ready, mul_ready, ld_ready, cdb_valid, cdb_rob_dest, cdb_rs_tag, cdb_data, cdb_taken
  );
  modport slave (
    input  flush, add_valid, mul_valid, ld_valid, add_rob_id, mul_rob_id, ld_rob_id,
           add_rs_tag, mul_rs_tag, ld_rs_tag, add_data, mul_data, ld_data, add_taken,
    output add_ready, mul_ready, ld_ready, cdb_valid, cdb_rob_dest, cdb_rs_tag, cdb_data, cdb_taken
  );
endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: DEPTH-entry skid FIFO of cdb_entry with synchronous flush
// Ports: clk, rst (async), flush, push/din, pop/dout, count, full, empty
module cdb_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  cdb_entry din,
  output cdb_entry dout,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  cdb_entry mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // full is judged on the registered count, so a full FIFO refuses a push even while popping
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty & ~flush;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of adder/multiplier/load results onto the registered CDB
// Ports: clk, rst (async), bus (cdb_arbiter_if.slave: unit handshakes, flush, cdb_* outputs)
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  cdb_arbiter_if.slave bus
);
  import cpu_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  cdb_entry din [3];
  cdb_entry dout [3];
  cdb_entry cdb_q;
  logic [CW-1:0] cnt [3];
  logic [2:0] vld, full, empty, req, pop;
  logic [1:0] ptr, win;
  logic any, cdb_v;
  assign vld = {bus.ld_valid, bus.mul_valid, bus.add_valid};
  assign din[0] = '{rob_id: bus.add_rob_id, rs_tag: bus.add_rs_tag, data: bus.add_data, taken: bus.add_taken};
  assign din[1] = '{rob_id: bus.mul_rob_id, rs_tag: bus.mul_rs_tag, data: bus.mul_data, taken: 1'b0};
  assign din[2] = '{rob_id: bus.ld_rob_id, rs_tag: bus.ld_rs_tag, data: bus.ld_data, taken: 1'b0};
  for (genvar i = 0; i < 3; i++) begin : g_src
    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk, .rst, .flush(bus.flush), .push(vld[i] & ~full[i]), .pop(pop[i]),
      .din(din[i]), .dout(dout[i]), .count(cnt[i]), .full(full[i]), .empty(empty[i])
    );
  end
  assign bus.add_ready = cnt[0] < CW'(FIFO_DEPTH);
  assign bus.mul_ready = cnt[1] < CW'(FIFO_DEPTH);
  assign bus.ld_ready = cnt[2] < CW'(FIFO_DEPTH);
  // only entries already stored at cycle start compete, so a fresh push waits one cycle
  assign req = ~empty;
  always_comb begin
    win = ptr == 2'd0 ? (req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2) :
          ptr == 2'd1 ? (req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd0) :
                        (req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd1);
    any = |req & ~bus.flush;
    pop = any ? 3'b001 << win : 3'b000;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      cdb_v <= 1'b0;
      cdb_q <= '0;
    end else begin
      cdb_v <= any;
      if (bus.flush) ptr <= '0;
      else if (any) begin
        ptr <= rr_next(win);
        cdb_q <= dout[win];
      end
    end
  assign bus.cdb_valid = cdb_v;
  assign bus.cdb_rob_dest = cdb_q.rob_id;
  assign bus.cdb_rs_tag = cdb_q.rs_tag;
  assign bus.cdb_data = cdb_q.data;
  assign bus.cdb_taken = cdb_q.taken;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus, queue-based reference model checked every cycle
module tb_cdb_arbiter;
  import cpu_pkg::*;
  typedef struct {int cyc; cdb_entry e;} seen_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cdb_arbiter_if bus();
  cdb_arbiter #(.FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  seen_t seen[$];
  cdb_entry q0[$], q1[$], q2[$];
  int mptr = 0;
  logic ev = 1'b0;
  cdb_entry ee = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find(input logic [63:0] d);
    for (int k = 0; k < seen.size(); k++) if (seen[k].e.data == d) return k;
    return -1;
  endfunction

  function automatic int qsize(input int s);
    return s == 0 ? q0.size() : s == 1 ? q1.size() : q2.size();
  endfunction

  // reference model: queues per source, oldest entries of the first non-empty source from ptr win
  always @(posedge clk or posedge rst) begin
    int pre[3];
    int w;
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      mptr = 0; ev = 1'b0; ee = '0;
    end else if (bus.flush) begin
      q0.delete(); q1.delete(); q2.delete();
      mptr = 0; ev = 1'b0;
    end else begin
      for (int s = 0; s < 3; s++) pre[s] = qsize(s);
      w = -1;
      for (int k = 0; k < 3; k++) if (w < 0 && pre[(mptr + k) % 3] > 0) w = (mptr + k) % 3;
      ev = w >= 0;
      if (w == 0) ee = q0.pop_front();
      if (w == 1) ee = q1.pop_front();
      if (w == 2) ee = q2.pop_front();
      if (w >= 0) mptr = (w + 1) % 3;
      if (bus.add_valid && pre[0] < 2) q0.push_back('{bus.add_rob_id, bus.add_rs_tag, bus.add_data, bus.add_taken});
      if (bus.mul_valid && pre[1] < 2) q1.push_back('{bus.mul_rob_id, bus.mul_rs_tag, bus.mul_data, 1'b0});
      if (bus.ld_valid && pre[2] < 2) q2.push_back('{bus.ld_rob_id, bus.ld_rs_tag, bus.ld_data, 1'b0});
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("cdb_valid", bus.cdb_valid, ev);
      chk("cdb_fields", {bus.cdb_rob_dest, bus.cdb_rs_tag, bus.cdb_data, bus.cdb_taken}, ee);
      chk("ready", {bus.ld_ready, bus.mul_ready, bus.add_ready},
          {q2.size() < 2, q1.size() < 2, q0.size() < 2});
      if (bus.cdb_valid) seen.push_back('{cyc, '{bus.cdb_rob_dest, bus.cdb_rs_tag, bus.cdb_data, bus.cdb_taken}});
    end
  end

  task automatic quiet();
    bus.flush = 0; bus.add_valid = 0; bus.mul_valid = 0; bus.ld_valid = 0; bus.add_taken = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      quiet();
    end
  endtask

  task automatic push(input logic [2:0] v, input logic [63:0] da, input logic [63:0] dm,
                      input logic [63:0] dl, input logic [1:0] rob, input logic tk, output int t0);
    @(negedge clk); #1;
    quiet();
    bus.add_valid = v[0]; bus.mul_valid = v[1]; bus.ld_valid = v[2];
    bus.add_data = da; bus.mul_data = dm; bus.ld_data = dl;
    bus.add_rob_id = rob; bus.mul_rob_id = rob + 2'd1; bus.ld_rob_id = rob + 2'd2;
    bus.add_rs_tag = add_1; bus.mul_rs_tag = mult_1; bus.ld_rs_tag = ld_1;
    bus.add_taken = tk;
    t0 = cyc;
  endtask

  task automatic do_flush();
    @(negedge clk); #1;
    quiet();
    bus.flush = 1;
    idle(2);
  endtask

  initial begin
    int t0, i, j, nm, nl, t_add, last_m, mcount;
    logic am, al, saw_full, mono;
    quiet();
    bus.add_data = 0; bus.mul_data = 0; bus.ld_data = 0;
    bus.add_rob_id = 0; bus.mul_rob_id = 0; bus.ld_rob_id = 0;
    bus.add_rs_tag = notag; bus.mul_rs_tag = notag; bus.ld_rs_tag = notag;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_ready", {bus.ld_ready, bus.mul_ready, bus.add_ready}, 3'b111);
    chk("rst_fields", {bus.cdb_rob_dest, bus.cdb_rs_tag, bus.cdb_data, bus.cdb_taken}, 0);
    #1 rst = 0;
    idle(10);
    chk("idle_no_bcast", seen.size(), 0);

    push(3'b001, 64'h1234, 0, 0, 2'd2, 1'b0, t0);
    idle(4);
    i = find(64'h1234);
    chk("single_found", i >= 0, 1);
    if (i >= 0) begin
      chk("single_latency", seen[i].cyc - t0, 2);
      chk("single_rob", seen[i].e.rob_id, 2);
      chk("single_tag", seen[i].e.rs_tag, 1);
      chk("single_taken", seen[i].e.taken, 0);
    end

    do_flush();
    push(3'b111, 64'hA, 64'hB, 64'hC, 2'd0, 1'b0, t0);
    idle(6);
    i = find(64'hA); chk("rr_A_cycle", i >= 0 ? seen[i].cyc - t0 : -1, 2);
    i = find(64'hB); chk("rr_B_cycle", i >= 0 ? seen[i].cyc - t0 : -1, 3);
    i = find(64'hC); chk("rr_C_cycle", i >= 0 ? seen[i].cyc - t0 : -1, 4);
    push(3'b011, 64'hD, 64'hE, 0, 2'd0, 1'b0, t0);
    idle(5);
    i = find(64'hD); chk("ptr_add_first", i >= 0 ? seen[i].cyc - t0 : -1, 2);
    i = find(64'hE); chk("ptr_mul_second", i >= 0 ? seen[i].cyc - t0 : -1, 3);

    push(3'b001, 64'hB0, 0, 0, 2'd1, 1'b1, t0);
    idle(4);
    i = find(64'hB0);
    chk("branch_taken", i >= 0 ? seen[i].e.taken : 1'bx, 1);
    chk("branch_rob", i >= 0 ? seen[i].e.rob_id : 2'bxx, 1);

    do_flush();
    nm = 1; nl = 1; am = 0; al = 0; saw_full = 0; t_add = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (am) nm++;
      if (al) nl++;
      bus.mul_valid = 1; bus.mul_data = 64'h1000 + 64'(nm); bus.mul_rob_id = 0; bus.mul_rs_tag = mult_1;
      bus.ld_valid = 1; bus.ld_data = 64'h2000 + 64'(nl); bus.ld_rob_id = 3; bus.ld_rs_tag = ld_1;
      bus.add_valid = k == 5; bus.add_data = 64'hADD; bus.add_rs_tag = add_2; bus.add_taken = 0;
      if (k == 5) begin
        t_add = cyc;
        chk("flood_add_ready", bus.add_ready, 1);
      end
      am = bus.mul_ready; al = bus.ld_ready;
      if (!bus.mul_ready) saw_full = 1;
    end
    idle(10);
    last_m = am ? nm : nm - 1;
    chk("mul_ready_dropped", saw_full, 1);
    i = find(64'hADD);
    chk("add_served_3", i >= 0 && seen[i].cyc - t_add <= 4, 1);
    mcount = 0; mono = 1;
    foreach (seen[k]) if (seen[k].e.rs_tag == mult_1 && seen[k].e.data >= 64'h1001 && seen[k].e.data < 64'h2000) begin
      mcount++;
      if (seen[k].e.data != 64'h1000 + 64'(mcount)) mono = 0;
    end
    chk("mul_in_order", mono, 1);
    chk("mul_none_lost", mcount, last_m);

    do_flush();
    push(3'b111, 64'hF1, 64'hF2, 64'hF3, 2'd0, 1'b0, t0);
    push(3'b100, 0, 0, 64'hF4, 2'd0, 1'b0, t0);
    @(negedge clk); #1;
    chk("ld_full_before_flush", bus.ld_ready, 0);
    quiet();
    bus.flush = 1; bus.add_valid = 1; bus.add_data = 64'hDEAD;
    @(negedge clk); #1;
    chk("flush_ready", {bus.ld_ready, bus.mul_ready, bus.add_ready}, 3'b111);
    chk("flush_no_valid", bus.cdb_valid, 0);
    quiet();
    idle(8);
    chk("flush_first_kept", find(64'hF1) >= 0, 1);
    chk("flush_mul_gone", find(64'hF2), -1);
    chk("flush_ld1_gone", find(64'hF3), -1);
    chk("flush_ld2_gone", find(64'hF4), -1);
    chk("flush_add_gone", find(64'hDEAD), -1);
    j = 0;
    foreach (seen[k]) if (seen[k].cyc > t0 + 1) j++;
    chk("flush_silence", j, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
